// File: rtl/stk_pkg.sv
// Shared configuration and type packages for the stack response controller.
package cfg_pkg;
  localparam int unsigned ENGS_N = 4;
endpackage

package stk_pkg;
  typedef logic [$clog2(cfg_pkg::ENGS_N)-1:0] engid_t;
  typedef logic [2:0]                         status_t;
endpackage

// File: rtl/stk_rsp_if.sv
// Issue / writeback / response bundle of stk_rsp_ctl.
// The timeout configuration inputs exist only when STK_RSP_TMO_EN is defined.
interface stk_rsp_if #(
  parameter int unsigned ENGS_N = cfg_pkg::ENGS_N,
  parameter int unsigned TMO_W  = 8
);
  logic                   i_iss_vld;
  stk_pkg::engid_t        i_iss_engid;
  logic [ENGS_N-1:0]      o_eng_busy;
  logic                   i_wrbk_vld;
  stk_pkg::engid_t        i_wrbk_engid;
  stk_pkg::status_t       i_wrbk_status;
  logic [127:0]           i_wrbk_dat;
  logic [ENGS_N-1:0]      o_rsp_vld;
  logic [ENGS_N-1:0]      i_rsp_rdy;
  logic [127:0]           o_rsp_dat;
  stk_pkg::status_t       o_rsp_status;
  logic                   o_err;
`ifdef STK_RSP_TMO_EN
  logic [TMO_W-1:0]       i_cfg_tmo;
  stk_pkg::status_t       i_cfg_tmo_status;
`endif

  if (TMO_W < 1) begin : g_tmo_w_chk
    $error("TMO_W must be at least 1");
  end

  // Controller side.
  modport slave (
    input  i_iss_vld, i_iss_engid, i_wrbk_vld, i_wrbk_engid, i_wrbk_status, i_wrbk_dat,
    input  i_rsp_rdy,
`ifdef STK_RSP_TMO_EN
    input  i_cfg_tmo, i_cfg_tmo_status,
`endif
    output o_eng_busy, o_rsp_vld, o_rsp_dat, o_rsp_status, o_err
  );

  // Pipeline / engine side.
  modport master (
    output i_iss_vld, i_iss_engid, i_wrbk_vld, i_wrbk_engid, i_wrbk_status, i_wrbk_dat,
    output i_rsp_rdy,
`ifdef STK_RSP_TMO_EN
    output i_cfg_tmo, i_cfg_tmo_status,
`endif
    input  o_eng_busy, o_rsp_vld, o_rsp_dat, o_rsp_status, o_err
  );
endinterface

// File: rtl/stk_rsp_ctl.sv
// Per-engine response controller: one outstanding command per engine, one buffered
// writeback per engine, round-robin sharing of a 128-bit response bus with grant lock.
// Optional macro STK_RSP_TMO_EN adds per-engine pending timeouts.
module stk_rsp_ctl #(
  parameter int unsigned ENGS_N = cfg_pkg::ENGS_N,
  parameter int unsigned TMO_W  = 8
) (
  input logic      clk,
  input logic      rst,
  stk_rsp_if.slave bus
);
  import stk_pkg::*;

  typedef enum logic [1:0] {StIdle, StPend, StHeld} eng_st_e;

  if (ENGS_N < 2) begin : g_engs_chk
    $error("ENGS_N must be at least 2");
  end
  if (TMO_W < 1) begin : g_tmo_w_chk
    $error("TMO_W must be at least 1");
  end

  eng_st_e      st_q  [ENGS_N];
  eng_st_e      st_d  [ENGS_N];
  logic [127:0] dat_q [ENGS_N];
  logic [127:0] dat_d [ENGS_N];
  status_t      sts_q [ENGS_N];
  status_t      sts_d [ENGS_N];
  engid_t       ptr_q, ptr_d;
  engid_t       gnt_q, gnt_d;
  engid_t       cand;
  logic         gnt_vld_q, gnt_vld_d;
  logic         err_q, err_d;
  logic         acc;
  logic [ENGS_N-1:0] tmo_hit;

`ifdef STK_RSP_TMO_EN
  logic [TMO_W-1:0] cnt_q   [ENGS_N];
  logic [TMO_W-1:0] cnt_d   [ENGS_N];
  logic [TMO_W-1:0] cnt_inc [ENGS_N];

  // Timeout detect; compares the count including the current pending cycle.
  always_comb begin
    tmo_hit = '0;
    for (int e = 0; e < ENGS_N; e++) begin
      cnt_inc[e] = (&cnt_q[e]) ? cnt_q[e] : cnt_q[e] + 1'b1;
      tmo_hit[e] = (st_q[e] == StPend) && (bus.i_cfg_tmo != '0) &&
                   (cnt_inc[e] == bus.i_cfg_tmo);
    end
  end
`else
  assign tmo_hit = '0;
`endif

  // Next-state for engine FSMs, error flag, pointer and grant.
  always_comb begin
    st_d  = st_q;
    dat_d = dat_q;
    sts_d = sts_q;
    err_d = err_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    gnt_vld_d = 1'b0;
    cand  = '0;
`ifdef STK_RSP_TMO_EN
    cnt_d = cnt_q;
`endif
    acc = gnt_vld_q && bus.i_rsp_rdy[gnt_q];
    if (acc) begin
      st_d[gnt_q] = StIdle;
      ptr_d = (gnt_q == engid_t'(ENGS_N - 1)) ? '0 : gnt_q + engid_t'(1);
    end
    for (int e = 0; e < ENGS_N; e++) begin
`ifdef STK_RSP_TMO_EN
      if (st_q[e] == StPend) cnt_d[e] = cnt_inc[e];
`endif
      // Writeback beats a same-cycle timeout.
      if (bus.i_wrbk_vld && bus.i_wrbk_engid == engid_t'(e)) begin
        if (st_q[e] != StPend) begin
          err_d = 1'b1;
        end else begin
          st_d[e]  = StHeld;
          dat_d[e] = bus.i_wrbk_dat;
          sts_d[e] = bus.i_wrbk_status;
        end
      end else if (tmo_hit[e]) begin
        st_d[e]  = StHeld;
        dat_d[e] = '0;
`ifdef STK_RSP_TMO_EN
        sts_d[e] = bus.i_cfg_tmo_status;
`endif
      end
      // Legality uses the current state, so issue during accept is still an error.
      if (bus.i_iss_vld && bus.i_iss_engid == engid_t'(e)) begin
        if (st_q[e] != StIdle) begin
          err_d = 1'b1;
        end else begin
          st_d[e] = StPend;
`ifdef STK_RSP_TMO_EN
          cnt_d[e] = '0;
`endif
        end
      end
    end
    // Hold an unaccepted grant; otherwise search from the pointer over next-state.
    if (gnt_vld_q && !acc) begin
      gnt_vld_d = 1'b1;
    end else begin
      for (int i = 0; i < ENGS_N; i++) begin
        cand = engid_t'((int'(ptr_d) + i) % ENGS_N);
        if (!gnt_vld_d && st_d[cand] == StHeld) begin
          gnt_vld_d = 1'b1;
          gnt_d     = cand;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENGS_N; e++) begin
        st_q[e]  <= StIdle;
        dat_q[e] <= '0;
        sts_q[e] <= '0;
`ifdef STK_RSP_TMO_EN
        cnt_q[e] <= '0;
`endif
      end
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      dat_q     <= dat_d;
      sts_q     <= sts_d;
`ifdef STK_RSP_TMO_EN
      cnt_q     <= cnt_d;
`endif
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      err_q     <= err_d;
    end
  end

  // Outputs decoded from flops only; no input-to-output path.
  always_comb begin
    bus.o_rsp_vld    = '0;
    bus.o_rsp_dat    = '0;
    bus.o_rsp_status = '0;
    bus.o_eng_busy   = '0;
    if (gnt_vld_q) begin
      bus.o_rsp_vld[gnt_q] = 1'b1;
      bus.o_rsp_dat        = dat_q[gnt_q];
      bus.o_rsp_status     = sts_q[gnt_q];
    end
    for (int e = 0; e < ENGS_N; e++) begin
      bus.o_eng_busy[e] = (st_q[e] != StIdle);
    end
    bus.o_err = err_q;
  end
endmodule

// File: tb/tb_stk_rsp_ctl.sv
// Self-checking bench for stk_rsp_ctl (ENGS_N = 4). Accepted responses are matched
// against a scoreboard of expected responses pushed when writebacks are driven.
module tb_stk_rsp_ctl;
  import stk_pkg::*;
  localparam int unsigned N = cfg_pkg::ENGS_N;

  typedef struct {
    int           eng;
    logic [127:0] dat;
    status_t      sts;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [N-1:0] mon_hs;
  int           mon_e;
  bit           mon_found;

  stk_rsp_if bus ();
  stk_rsp_ctl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_iss_vld     = 1'b0;
    bus.i_iss_engid   = '0;
    bus.i_wrbk_vld    = 1'b0;
    bus.i_wrbk_engid  = '0;
    bus.i_wrbk_status = '0;
    bus.i_wrbk_dat    = '0;
    bus.i_rsp_rdy     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input int e);
    bus.i_iss_vld   = 1'b1;
    bus.i_iss_engid = engid_t'(e);
    step();
    bus.i_iss_vld   = 1'b0;
  endtask

  task automatic set_wb(input int e, input logic [127:0] d, input status_t s, input bit push);
    exp_t x;
    bus.i_wrbk_vld    = 1'b1;
    bus.i_wrbk_engid  = engid_t'(e);
    bus.i_wrbk_dat    = d;
    bus.i_wrbk_status = s;
    if (push) begin
      x.eng = e; x.dat = d; x.sts = s;
      sb.push_back(x);
    end
  endtask

  task automatic clr_wb();
    bus.i_wrbk_vld = 1'b0;
  endtask

  // Scoreboard: every handshake must match an outstanding expected response.
  always @(negedge clk) begin
    if (!rst) begin
      mon_hs = bus.o_rsp_vld & bus.i_rsp_rdy;
      if (mon_hs != '0) begin
        checks++;
        if (!$onehot(bus.o_rsp_vld)) begin
          errors++;
          $display("FAIL rsp_onehot: got %b want one-hot", bus.o_rsp_vld);
        end
        mon_e = 0;
        for (int i = 0; i < N; i++) if (mon_hs[i]) mon_e = i;
        mon_found = 1'b0;
        for (int k = 0; k < sb.size(); k++) begin
          if (!mon_found && sb[k].eng == mon_e) begin
            mon_found = 1'b1;
            checks++;
            if (bus.o_rsp_dat !== sb[k].dat || bus.o_rsp_status !== sb[k].sts) begin
              errors++;
              $display("FAIL sb_eng%0d: got dat %h sts %0d want dat %h sts %0d", mon_e,
                       bus.o_rsp_dat, bus.o_rsp_status, sb[k].dat, sb[k].sts);
            end
            sb.delete(k);
          end
        end
        if (!mon_found) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got response on eng %0d want none", mon_e);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus.o_eng_busy !== '0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.o_eng_busy); end
    checks++; if (bus.o_rsp_vld !== '0) begin errors++; $display("FAIL rst_vld: got %b want 0", bus.o_rsp_vld); end
    checks++; if (bus.o_rsp_dat !== '0) begin errors++; $display("FAIL rst_dat: got %h want 0", bus.o_rsp_dat); end
    checks++; if (bus.o_rsp_status !== '0) begin errors++; $display("FAIL rst_sts: got %0d want 0", bus.o_rsp_status); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.o_err); end
    step();
  endtask

  task automatic test_basic();
    issue(1);
    @(negedge clk);
    checks++; if (bus.o_eng_busy !== 4'b0010) begin errors++; $display("FAIL basic_busy_pend: got %b want 0010", bus.o_eng_busy); end
    step();
    set_wb(1, 128'hA5, 3'd1, 1'b1);
    bus.i_rsp_rdy = 4'b0010;
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 4'b0000) begin errors++; $display("FAIL basic_no_bypass: got %b want 0000", bus.o_rsp_vld); end
    step();
    clr_wb();
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 4'b0010) begin errors++; $display("FAIL basic_vld: got %b want 0010", bus.o_rsp_vld); end
    checks++; if (bus.o_rsp_dat !== 128'hA5 || bus.o_rsp_status !== 3'd1) begin errors++; $display("FAIL basic_dat: got %h/%0d want a5/1", bus.o_rsp_dat, bus.o_rsp_status); end
    checks++; if (bus.o_eng_busy !== 4'b0010) begin errors++; $display("FAIL basic_busy_held: got %b want 0010", bus.o_eng_busy); end
    step();
    bus.i_rsp_rdy = '0;
    @(negedge clk);
    checks++; if (bus.o_eng_busy !== 4'b0000 || bus.o_rsp_vld !== 4'b0000) begin errors++; $display("FAIL basic_done: got busy %b vld %b want 0000 0000", bus.o_eng_busy, bus.o_rsp_vld); end
    step();
  endtask

  task automatic test_rr();
    logic [N-1:0] want;
    do_reset();
    for (int e = 0; e < N; e++) issue(e);
    for (int e = 0; e < N; e++) begin
      set_wb(e, 128'h100 + 128'(e), status_t'(e), 1'b1);
      step();
    end
    clr_wb();
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 4'b0001) begin errors++; $display("FAIL rr_lock0: got %b want 0001", bus.o_rsp_vld); end
    step();
    bus.i_rsp_rdy = '1;
    for (int k = 0; k < N; k++) begin
      want = '0;
      want[k] = 1'b1;
      @(negedge clk);
      checks++; if (bus.o_rsp_vld !== want) begin errors++; $display("FAIL rr_seq%0d: got %b want %b", k, bus.o_rsp_vld, want); end
      step();
    end
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== '0 || bus.o_eng_busy !== '0) begin errors++; $display("FAIL rr_empty: got vld %b busy %b want 0 0", bus.o_rsp_vld, bus.o_eng_busy); end
    step();
    bus.i_rsp_rdy = '0;
  endtask

  // Pointer 0: grant locks on 1, then 3 and 0 follow by wrap-around.
  task automatic test_wrap();
    logic [N-1:0] seq [3];
    seq[0] = 4'b0010; seq[1] = 4'b1000; seq[2] = 4'b0001;
    issue(0); issue(1); issue(3);
    set_wb(1, 128'h11, 3'd1, 1'b1); step();
    set_wb(0, 128'h10, 3'd0, 1'b1); step();
    set_wb(3, 128'h13, 3'd3, 1'b1); step();
    clr_wb();
    bus.i_rsp_rdy = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.o_rsp_vld !== seq[k]) begin errors++; $display("FAIL wrap_seq%0d: got %b want %b", k, bus.o_rsp_vld, seq[k]); end
      step();
    end
    bus.i_rsp_rdy = '0;
  endtask

  // Pointer 1 after accepting 0: grant 2, locked while 0 becomes held.
  task automatic test_lock();
    issue(2); issue(0);
    bus.i_rsp_rdy = 4'b0001;
    set_wb(2, 128'hD2D2, 3'd2, 1'b1); step();
    set_wb(0, 128'hD0D0, 3'd4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.o_rsp_vld !== 4'b0100 || bus.o_rsp_dat !== 128'hD2D2) begin errors++; $display("FAIL lock_hold%0d: got %b %h want 0100 d2d2", k, bus.o_rsp_vld, bus.o_rsp_dat); end
      step();
      clr_wb();
    end
    checks++; if (bus.o_eng_busy !== 4'b0101) begin errors++; $display("FAIL lock_busy: got %b want 0101", bus.o_eng_busy); end
    bus.i_rsp_rdy = 4'b0101;
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 4'b0100) begin errors++; $display("FAIL lock_acc: got %b want 0100", bus.o_rsp_vld); end
    step();
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 4'b0001 || bus.o_rsp_dat !== 128'hD0D0) begin errors++; $display("FAIL lock_next: got %b %h want 0001 d0d0", bus.o_rsp_vld, bus.o_rsp_dat); end
    step();
    bus.i_rsp_rdy = '0;
  endtask

  task automatic test_err();
    set_wb(3, 128'hBAD, 3'd5, 1'b0); step(); clr_wb();
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b1 || bus.o_eng_busy !== 4'b0000 || bus.o_rsp_vld !== 4'b0000) begin errors++; $display("FAIL err_wb_idle: got err %b busy %b vld %b want 1 0000 0000", bus.o_err, bus.o_eng_busy, bus.o_rsp_vld); end
    step();
    issue(1);
    set_wb(1, 128'h77, 3'd3, 1'b1); step(); clr_wb();
    step();
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b1 || bus.o_rsp_vld !== 4'b0010) begin errors++; $display("FAIL err_sticky: got err %b vld %b want 1 0010", bus.o_err, bus.o_rsp_vld); end
    step();
    do_reset();
    @(negedge clk);
    checks++; if ({bus.o_err, bus.o_eng_busy, bus.o_rsp_vld} !== '0 || bus.o_rsp_dat !== '0 || bus.o_rsp_status !== '0) begin errors++; $display("FAIL err_rst: got err %b busy %b vld %b dat %h want all 0", bus.o_err, bus.o_eng_busy, bus.o_rsp_vld, bus.o_rsp_dat); end
    step();
  endtask

  task automatic test_acc_iss();
    issue(0);
    set_wb(0, 128'h55, 3'd6, 1'b1); step(); clr_wb();
    bus.i_rsp_rdy   = 4'b0001;
    bus.i_iss_vld   = 1'b1;
    bus.i_iss_engid = engid_t'(0);
    step();
    idle_in();
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b1 || bus.o_eng_busy !== 4'b0000) begin errors++; $display("FAIL acc_iss: got err %b busy %b want 1 0000", bus.o_err, bus.o_eng_busy); end
    step();
    do_reset();
  endtask

  task automatic test_simul();
    issue(1);
    bus.i_iss_vld   = 1'b1;
    bus.i_iss_engid = engid_t'(2);
    set_wb(1, 128'h21, 3'd1, 1'b1);
    step();
    idle_in();
    @(negedge clk);
    checks++; if (bus.o_eng_busy !== 4'b0110 || bus.o_rsp_vld !== 4'b0010) begin errors++; $display("FAIL simul_iss_wb: got busy %b vld %b want 0110 0010", bus.o_eng_busy, bus.o_rsp_vld); end
    step();
    bus.i_rsp_rdy = 4'b0010;
    set_wb(2, 128'h22, 3'd2, 1'b1);
    step();
    idle_in();
    @(negedge clk);
    checks++; if (bus.o_eng_busy !== 4'b0100 || bus.o_rsp_vld !== 4'b0100 || bus.o_err !== 1'b0) begin errors++; $display("FAIL simul_wb_acc: got busy %b vld %b err %b want 0100 0100 0", bus.o_eng_busy, bus.o_rsp_vld, bus.o_err); end
    step();
    bus.i_rsp_rdy = 4'b0100;
    step();
    bus.i_rsp_rdy = '0;
    @(negedge clk);
    checks++; if (bus.o_eng_busy !== 4'b0000) begin errors++; $display("FAIL simul_done: got %b want 0000", bus.o_eng_busy); end
    step();
  endtask

`ifdef STK_RSP_TMO_EN
  task automatic test_tmo();
    exp_t x;
    do_reset();
    bus.i_cfg_tmo = 8'd4;
    bus.i_cfg_tmo_status = 3'd7;
    x.eng = 1; x.dat = '0; x.sts = 3'd7;
    sb.push_back(x);
    issue(1);
    step(); step(); step();
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 4'b0000) begin errors++; $display("FAIL tmo_early: got %b want 0000", bus.o_rsp_vld); end
    step();
    bus.i_rsp_rdy = 4'b0010;
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 4'b0010 || bus.o_rsp_dat !== '0 || bus.o_rsp_status !== 3'd7) begin errors++; $display("FAIL tmo_rsp: got %b %h %0d want 0010 0 7", bus.o_rsp_vld, bus.o_rsp_dat, bus.o_rsp_status); end
    step();
    bus.i_rsp_rdy = '0;
    set_wb(1, 128'h99, 3'd1, 1'b0); step(); clr_wb();
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL tmo_late_wb: got err %b want 1", bus.o_err); end
    step();
    do_reset();
    issue(2);
    step(); step(); step();
    set_wb(2, 128'hAB, 3'd2, 1'b1); step(); clr_wb();
    bus.i_rsp_rdy = 4'b0100;
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 4'b0100 || bus.o_rsp_dat !== 128'hAB || bus.o_rsp_status !== 3'd2) begin errors++; $display("FAIL tmo_wb_wins: got %b %h %0d want 0100 ab 2", bus.o_rsp_vld, bus.o_rsp_dat, bus.o_rsp_status); end
    step();
    bus.i_rsp_rdy = '0;
    bus.i_cfg_tmo = '0;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_in();
`ifdef STK_RSP_TMO_EN
    bus.i_cfg_tmo        = '0;
    bus.i_cfg_tmo_status = '0;
`endif
    test_reset();
    test_basic();
    test_rr();
    test_wrap();
    test_lock();
    test_err();
    test_acc_iss();
    test_simul();
`ifdef STK_RSP_TMO_EN
    test_tmo();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
